// File: rtl/prra_grant_ctrl.sv
// Round-robin grant controller for one router output port.
// Holds the winner for a whole packet and re-arbitrates on its end-of-packet flit with no bubble.
module prra_grant_ctrl #(
  parameter int WIDTH      = 4,
  parameter int LOG2_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [WIDTH-1:0]      request,
  input  logic [WIDTH-1:0]      eop,
  input  logic                  xfer,
  output logic [WIDTH-1:0]      grant,
  output logic [LOG2_WIDTH-1:0] grant_idx,
  output logic                  grant_valid
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state_r;
  logic [LOG2_WIDTH-1:0]   last_idx_r;
  logic [WIDTH-1:0]        grant_r;
  logic [LOG2_WIDTH-1:0]   grant_idx_r;
  logic                    grant_valid_r;

  logic                    found_s;
  logic [LOG2_WIDTH-1:0]   win_idx_s;
  logic [LOG2_WIDTH-1:0]   cand_s;
  int                      cand_int_s;
  logic                    release_s;

  // Rotating search: first requesting port after last_idx_r, wrapping modulo WIDTH.
  // While locked last_idx_r equals grant_idx_r, so the released port ends up lowest priority.
  always_comb begin
    found_s    = 1'b0;
    win_idx_s  = {LOG2_WIDTH{1'b0}};
    cand_s     = {LOG2_WIDTH{1'b0}};
    cand_int_s = 0;
    for (int k = 0; k < WIDTH; k++) begin
      cand_int_s = (int'(last_idx_r) + 1 + k) % WIDTH;
      cand_s     = LOG2_WIDTH'(cand_int_s);
      if (!found_s && request[cand_s]) begin
        found_s   = 1'b1;
        win_idx_s = cand_s;
      end else begin
      end
    end
  end

  // Only the granted port's end-of-packet flit, actually transferred, ends the lock.
  always_comb begin
    if (state_r == LOCKED) begin
      release_s = xfer & eop[grant_idx_r];
    end else begin
      release_s = 1'b0;
    end
  end

  // Grant FSM with registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r       <= IDLE;
      last_idx_r    <= LOG2_WIDTH'(WIDTH - 1);
      grant_r       <= {WIDTH{1'b0}};
      grant_idx_r   <= {LOG2_WIDTH{1'b0}};
      grant_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r       <= LOCKED;
            last_idx_r    <= win_idx_s;
            grant_r       <= {{(WIDTH-1){1'b0}}, 1'b1} << win_idx_s;
            grant_idx_r   <= win_idx_s;
            grant_valid_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        LOCKED: begin
          if (release_s && found_s) begin
            state_r       <= LOCKED;
            last_idx_r    <= win_idx_s;
            grant_r       <= {{(WIDTH-1){1'b0}}, 1'b1} << win_idx_s;
            grant_idx_r   <= win_idx_s;
            grant_valid_r <= 1'b1;
          end else if (release_s) begin
            state_r       <= IDLE;
            grant_r       <= {WIDTH{1'b0}};
            grant_valid_r <= 1'b0;
          end else begin
            state_r <= LOCKED;
          end
        end
        default: begin
          state_r       <= IDLE;
          grant_r       <= {WIDTH{1'b0}};
          grant_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = grant_r;
  assign grant_idx   = grant_idx_r;
  assign grant_valid = grant_valid_r;

endmodule
